// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the skid-buffer pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int c_occ_w = 2;

    // Encoding equals the entry count so occupancy is the state itself.
    typedef enum logic [c_occ_w-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_ctrl
// Description : Two-entry skid buffer control FSM; produces register enables.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_flush,
    input  logic   i_in_valid,
    input  logic   i_out_ready,
    output state_t o_state,
    output logic   o_in_ready,
    output logic   o_out_valid,
    output logic   o_main_load,
    output logic   o_skid_load,
    output logic   o_main_sel_skid
);

    state_t r_state;
    state_t w_next;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_consume;

    assign w_accept  = i_in_valid & r_in_ready;
    assign w_consume = (r_state != EMPTY) & i_out_ready;

    always_comb begin
        w_next          = r_state;
        o_main_load     = 1'b0;
        o_skid_load     = 1'b0;
        o_main_sel_skid = 1'b0;
        if (i_flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next      = BUSY;
                        o_main_load = 1'b1;
                    end
                end
                BUSY: begin
                    if (w_accept && w_consume) begin
                        o_main_load = 1'b1;
                    end else if (w_consume) begin
                        w_next = EMPTY;
                    end else if (w_accept) begin
                        w_next      = FULL;
                        o_skid_load = 1'b1;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_next          = BUSY;
                        o_main_load     = 1'b1;
                        o_main_sel_skid = 1'b1;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // in_ready is precomputed from the next state so it leaves a flop directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
        end
    end

    assign o_state     = r_state;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_state != EMPTY);

endmodule : pipe_skid_ctrl
`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buffer
// Description : Two-entry valid/ready skid buffer with registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int LENGTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LENGTH-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LENGTH-1:0]  out_data,
    output logic [c_occ_w-1:0] occupancy
);

    state_t            w_state;
    logic              w_main_load;
    logic              w_skid_load;
    logic              w_main_sel_skid;
    logic [LENGTH-1:0] w_main_d;
    logic [LENGTH-1:0] r_main;
    logic [LENGTH-1:0] r_skid;

    pipe_skid_ctrl u_ctrl (
        .clk             (clk),
        .reset           (reset),
        .i_flush         (flush),
        .i_in_valid      (in_valid),
        .i_out_ready     (out_ready),
        .o_state         (w_state),
        .o_in_ready      (in_ready),
        .o_out_valid     (out_valid),
        .o_main_load     (w_main_load),
        .o_skid_load     (w_skid_load),
        .o_main_sel_skid (w_main_sel_skid)
    );

    assign w_main_d = w_main_sel_skid ? r_skid : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
        end else if (w_main_load) begin
            r_main <= w_main_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid <= '0;
        end else if (w_skid_load) begin
            r_skid <= in_data;
        end
    end

    assign out_data  = r_main;
    assign occupancy = c_occ_w'(w_state);

endmodule : pipe_skid_buffer
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_buffer
// Description : Directed and randomized self-checking bench for pipe_skid_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buffer;

    localparam int LENGTH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LENGTH-1:0] q[$];

    pipe_skid_buffer #(.LENGTH(LENGTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LENGTH-1:0] obs, input logic [LENGTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic iv, input logic ov, input logic [1:0] occ);
        chk({tag, ".in_ready"}, LENGTH'(in_ready), LENGTH'(iv));
        chk({tag, ".out_valid"}, LENGTH'(out_valid), LENGTH'(ov));
        chk({tag, ".occupancy"}, LENGTH'(occupancy), LENGTH'(occ));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk_state("reset", 1'b1, 1'b0, 2'd0);
        chk("reset.out_data", out_data, '0);
        #2 reset = 1'b0;

        // Streaming: back-to-back transfers, one cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = LENGTH'(i);
            cyc();
            chk($sformatf("stream%0d.data", i), out_data, LENGTH'(i));
            chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk_state("stream_drain", 1'b1, 1'b0, 2'd0);

        // Backpressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        cyc();
        in_data   = 64'hB;
        cyc();
        in_valid  = 1'b0;
        chk_state("bp_full", 1'b0, 1'b1, 2'd2);
        chk("bp_full.data", out_data, 64'hA);
        cyc();
        chk("bp_hold.data", out_data, 64'hA);
        out_ready = 1'b1;
        cyc();
        chk("bp_pop1.data", out_data, 64'hB);
        chk_state("bp_pop1", 1'b1, 1'b1, 2'd1);
        cyc();
        chk_state("bp_pop2", 1'b1, 1'b0, 2'd0);

        // Accept and consume together in BUSY.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        cyc();
        chk("sim_busy.data", out_data, 64'h5);
        in_data   = 64'h6;
        out_ready = 1'b1;
        cyc();
        chk("sim.data", out_data, 64'h6);
        chk_state("sim", 1'b1, 1'b1, 2'd1);
        in_valid = 1'b0;
        cyc();
        chk_state("sim_drain", 1'b1, 1'b0, 2'd0);

        // Flush from FULL with a coincident offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hC;
        cyc();
        in_data   = 64'hD;
        cyc();
        chk_state("fl_full", 1'b0, 1'b1, 2'd2);
        flush     = 1'b1;
        in_data   = 64'hE;
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk_state("flush", 1'b1, 1'b0, 2'd0);
        cyc();
        chk_state("flush_after", 1'b1, 1'b0, 2'd0);

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        cyc();
        in_data   = 64'h22;
        cyc();
        in_valid  = 1'b0;
        chk_state("rst_full", 1'b0, 1'b1, 2'd2);
        #2 reset = 1'b1;
        #1;
        chk_state("rst_mid", 1'b1, 1'b0, 2'd0);
        chk("rst_mid.data", out_data, '0);
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        out_ready = 1'b1;
        cyc();
        chk("rst_after.data", out_data, 64'h77);
        chk_state("rst_after", 1'b1, 1'b1, 2'd1);
        in_valid = 1'b0;
        cyc();
        chk_state("rst_drain", 1'b1, 1'b0, 2'd0);

        // Random stall against a queue model of at most two entries.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic acc;
            logic con;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = {32'($urandom), 32'(c)};
            chk("rnd.in_ready", LENGTH'(in_ready), LENGTH'(q.size() < 2));
            chk("rnd.out_valid", LENGTH'(out_valid), LENGTH'(q.size() > 0));
            chk("rnd.occupancy", LENGTH'(occupancy), LENGTH'(q.size()));
            if (q.size() > 0) chk("rnd.data", out_data, q[0]);
            acc = in_valid && (q.size() < 2);
            con = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            cyc();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("rnd_end.occupancy", LENGTH'(occupancy), LENGTH'(q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_buffer
`default_nettype wire
